// File: rtl/merge_operand_stager.sv
// Registered operand stager for the combinational merge/shift stage: collects A then B (+mode),
// holds them stable, captures the merge result. Optional out_par via MERGE_STAGER_PARITY_EN.
module merge_operand_stager #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MODE_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_second,
  input  logic [MODE_W-1:0] in_mode,
  output logic [DATA_W-1:0] mg_a,
  output logic [DATA_W-1:0] mg_b,
  output logic [MODE_W-1:0] mg_mode,
  input  logic [DATA_W-1:0] mg_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  pair_cnt
`ifdef MERGE_STAGER_PARITY_EN
  ,
  output logic              out_par
`endif
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHaveA = 3'd1;
  localparam logic [2:0] StEval  = 3'd2;
  localparam logic [2:0] StOut   = 3'd3;
  localparam logic [2:0] StOutA  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] mg_a_q, mg_a_d;
  logic [DATA_W-1:0] mg_b_q, mg_b_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;
  logic              err_pend_q, err_pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              accept, acc_a, acc_b;

  // Ready depends on registered state only, never on the input beat.
  assign in_ready = (state_q == StIdle) || (state_q == StHaveA) || (state_q == StOut);
  assign accept   = in_valid & in_ready;
  assign acc_a    = accept & ~in_second;
  assign acc_b    = accept & in_second;

  always_comb begin
    state_d     = state_q;
    mg_a_d      = mg_a_q;
    mg_b_d      = mg_b_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    err_pend_d  = err_pend_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    case (state_q)
      StIdle: begin
        if (acc_a) begin
          mg_a_d  = in_data;
          state_d = StHaveA;
        end else if (acc_b) begin
          err_pend_d = 1'b1;
        end
      end
      StHaveA: begin
        if (acc_b) begin
          mg_b_d  = in_data;
          mode_d  = in_mode;
          state_d = StEval;
        end else if (acc_a) begin
          mg_a_d     = in_data;
          err_pend_d = 1'b1;
        end
      end
      StEval: begin
        out_data_d  = mg_result;
        par_d       = ^mg_result;
        out_err_d   = err_pend_q;
        err_pend_d  = 1'b0;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        // A stray B here flags the next pair; the held result keeps its own flag.
        if (acc_b) err_pend_d = 1'b1;
        if (acc_a) mg_a_d = in_data;
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = acc_a ? StHaveA : StIdle;
        end else if (acc_a) begin
          state_d = StOutA;
        end
      end
      StOutA: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = StHaveA;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mg_a_q      <= '0;
      mg_b_q      <= '0;
      mode_q      <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_pend_q  <= 1'b0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mg_a_q      <= mg_a_d;
      mg_b_q      <= mg_b_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      err_pend_q  <= err_pend_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
    end
  end

  assign mg_a      = mg_a_q;
  assign mg_b      = mg_b_q;
  assign mg_mode   = mode_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign pair_cnt  = cnt_q;
`ifdef MERGE_STAGER_PARITY_EN
  assign out_par   = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_merge_operand_stager.sv
// Scoreboard bench for merge_operand_stager: pairing model feeds an expected queue, a negedge
// monitor pops and compares on every output handshake.
module tb_merge_operand_stager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_second = 1'b0;
  logic [2:0]  in_mode = '0;
  logic [15:0] mg_a, mg_b, mg_result, out_data;
  logic [2:0]  mg_mode;
  logic        out_valid, out_err;
  logic        out_ready = 1'b0;
  logic [7:0]  pair_cnt;
`ifdef MERGE_STAGER_PARITY_EN
  logic        out_par;
`endif

  merge_operand_stager dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_second (in_second),
    .in_mode   (in_mode),
    .mg_a      (mg_a),
    .mg_b      (mg_b),
    .mg_mode   (mg_mode),
    .mg_result (mg_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .pair_cnt  (pair_cnt)
`ifdef MERGE_STAGER_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in merge stage: s selects AND/OR, t xors byte-swapped B, u adds A>>1.
  function automatic logic [15:0] merge_f(logic [15:0] a, logic [15:0] b, logic [2:0] m);
    logic [15:0] r;
    r = m[0] ? (a & b) : (a | b);
    if (m[1]) r = r ^ {b[7:0], b[15:8]};
    if (m[2]) r = r + {1'b0, a[15:1]};
    return r;
  endfunction

  assign mg_result = merge_f(mg_a, mg_b, mg_mode);

  typedef struct {
    logic [15:0] d;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  int          bedge_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          rdy_mode = 1;
  int          prev_hs = -1;
  bit          tput_on = 0;
  bit          prev_ov = 0;
  logic [15:0] m_a = '0;
  bit          m_have_a = 0;
  bit          m_err = 0;
  logic [7:0]  exp_cnt = '0;
  logic [15:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    bedge_q.delete();
    m_have_a = 0;
    m_err    = 0;
    exp_cnt  = '0;
    prev_hs  = -1;
  endtask

  // Offer one beat until accepted, then update the pairing model.
  task automatic send(input bit sec, input logic [15:0] d, input logic [2:0] m);
    bit          acc;
    int          g;
    int          bcyc;
    logic [15:0] res;
    acc = 0;
    g   = 0;
    in_valid = 1'b1; in_second = sec; in_data = d; in_mode = m;
    while (!acc && g < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      g++;
    end
    bcyc = cyc;
    #1;
    in_valid = 1'b0; in_second = 1'b0; in_data = 16'($urandom); in_mode = 3'($urandom);
    if (!acc) begin
      fail_now("accept_timeout");
      return;
    end
    if (!sec) begin
      if (m_have_a) m_err = 1;
      m_a = d;
      m_have_a = 1;
      chk("mg_a_load", mg_a, d);
    end else if (!m_have_a) begin
      m_err = 1;
      chk("stray_b_in_ready", in_ready, 1);
    end else begin
      res = merge_f(m_a, d, m);
      exp_q.push_back('{d: res, e: m_err});
      bedge_q.push_back(bcyc);
      last_res = res;
      m_err = 0;
      m_have_a = 0;
      chk("eval_in_ready", in_ready, 0);
      chk("eval_mg_a", mg_a, m_a);
      chk("eval_mg_b", mg_b, d);
      chk("eval_mg_mode", mg_mode, m);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_pair_cnt"}, pair_cnt, 0);
    chk({tag, "_mg_a"}, mg_a, 0);
    chk({tag, "_mg_b"}, mg_b, 0);
    chk({tag, "_mg_mode"}, mg_mode, 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'($urandom);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t x;
    int   e;
    cyc++;
    if (rst_n) begin
      // B accepted at the edge before cycle e; EVAL occupies one cycle before out_valid.
      if (out_valid && !prev_ov) begin
        if (bedge_q.size() == 0) fail_now("valid_without_pair");
        else begin
          e = bedge_q.pop_front();
          chk("latency", cyc - e, 2);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else begin
          x = exp_q.pop_front();
          chk("out_data", out_data, x.d);
          chk("out_err", out_err, x.e);
          chk("pair_cnt", pair_cnt, exp_cnt);
`ifdef MERGE_STAGER_PARITY_EN
          chk("out_par", out_par, ^x.d);
`endif
        end
        exp_cnt++;
        if (tput_on && prev_hs >= 0) chk("throughput", cyc - prev_hs, 3);
        prev_hs = cyc;
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);

    // Basic pair.
    rdy_mode = 1;
    send(0, 16'h1234, 3'd0);
    send(1, 16'hABCD, 3'd4);
    drain();
    chk("first_pair_cnt", pair_cnt, 1);

    // Stray B, then two clean pairs: only the first carries the error.
    send(1, 16'h00FF, 3'd0);
    send(0, 16'h0F0F, 3'd0);
    send(1, 16'hF00F, 3'd3);
    send(0, 16'h7777, 3'd0);
    send(1, 16'h8888, 3'd5);
    drain();

    // Double A: second one wins.
    send(0, 16'h1111, 3'd0);
    send(0, 16'h2222, 3'd0);
    send(1, 16'h3333, 3'd1);
    drain();

    // Output stall with an A offered during OUT.
    rdy_mode = 2;
    send(0, 16'h4444, 3'd0);
    send(1, 16'h6666, 3'd2);
    send(0, 16'h5555, 3'd0);
    for (int i = 0; i < 5; i++) begin
      chk("outa_in_ready", in_ready, 0);
      chk("outa_out_valid", out_valid, 1);
      chk("outa_out_data", out_data, last_res);
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    g = 0;
    while (out_valid && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("outa_release", out_valid, 0);
    chk("outa_mg_a", mg_a, 16'h5555);
    chk("outa_in_ready", in_ready, 1);
    chk("outa_pair_cnt", pair_cnt, exp_cnt);
    send(1, 16'h0001, 3'd6);
    drain();

    // Random traffic with random backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      bit sec;
      sec = m_have_a ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
      send(sec, 16'($urandom), 3'($urandom));
    end
    rdy_mode = 1;
    drain();

    // Back-to-back burst: counter wrap and 3-cycle cadence.
    prev_hs = -1;
    tput_on = 1;
    for (int i = 0; i < 256; i++) begin
      send(0, 16'($urandom), 3'd0);
      send(1, 16'($urandom), 3'($urandom));
    end
    drain();
    tput_on = 0;
    chk("burst_pair_cnt", pair_cnt, exp_cnt);

    // Reset during EVAL.
    send(0, 16'hA5A5, 3'd0);
    send(1, 16'h5A5A, 3'd7);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_eval");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_eval_in_ready", in_ready, 1);

    // Reset while a result is held in OUT.
    rdy_mode = 2;
    send(0, 16'hC3C3, 3'd0);
    send(1, 16'h3C3C, 3'd2);
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_out");
    model_reset();
    rdy_mode = 1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_in_ready", in_ready, 1);
    send(0, 16'h0102, 3'd0);
    send(1, 16'h0304, 3'd1);
    drain();
    chk("post_rst_pair_cnt", pair_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
